// File: rtl/sccb_reg_slave.sv
// rtl/sccb_reg_slave.sv - SCCB/I2C target capturing 16-bit-address register writes as strobes
// Read path (RD/MACK states, rd_req/rd_addr/rd_data) is built only when SCCB_SLAVE_READ_EN is defined.
module sccb_reg_slave #(
    parameter logic [6:0] DEV_ADDR   = 7'h3C,
    parameter int         FILTER_LEN = 3
) (
    input  logic        clk_25M,
    input  logic        camera_rst,
    input  logic        i2c_sclk,
    input  logic        i2c_sdat_in,
    output logic        i2c_sdat_oe,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic [8:0]  wr_count
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    // index 1 = SCL, index 0 = SDA; idle bus level is high
    logic [1:0]    sync1, sync2, filt, filt_d;
    logic [CW-1:0] flt_cnt [2];

    always_ff @(posedge clk_25M) begin
        if (camera_rst) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            filt       <= 2'b11;
            filt_d     <= 2'b11;
            flt_cnt[0] <= '0;
            flt_cnt[1] <= '0;
        end else begin
            sync1  <= {i2c_sclk, i2c_sdat_in};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + CW'(1);
                end
            end
        end
    end

    logic sda_f, scl_rise, scl_fall, start_c, stop_c;
    assign sda_f    = filt[0];
    assign scl_rise = filt[1] & ~filt_d[1];
    assign scl_fall = ~filt[1] & filt_d[1];
    assign start_c  = ~filt[0] & filt_d[0] & filt[1] & filt_d[1];
    assign stop_c   = filt[0] & ~filt_d[0] & filt[1] & filt_d[1];

    typedef enum logic [2:0] {IDLE, DEV, AH, AL, WR, RD, MACK, WAIT_STOP} state_t;
    state_t      state, ack_next;
    logic        ack_phase;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [15:0] addr;
`ifdef SCCB_SLAVE_READ_EN
    logic       addr_set;
    logic [1:0] rd_stage;
    logic       mack_ok;
`else
    logic unused_rd;
    assign unused_rd = ^rd_data;
    assign rd_req    = 1'b0;
    assign rd_addr   = 16'h0000;
`endif

    always_ff @(posedge clk_25M) begin
        if (camera_rst) begin
            state       <= IDLE;
            ack_next    <= IDLE;
            ack_phase   <= 1'b0;
            bit_cnt     <= 4'd0;
            shreg       <= 8'h00;
            addr        <= 16'h0000;
            i2c_sdat_oe <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= 16'h0000;
            wr_data     <= 8'h00;
            busy        <= 1'b0;
            wr_count    <= 9'd0;
`ifdef SCCB_SLAVE_READ_EN
            addr_set    <= 1'b0;
            rd_stage    <= 2'd0;
            mack_ok     <= 1'b0;
            rd_req      <= 1'b0;
            rd_addr     <= 16'h0000;
`endif
        end else begin
            wr_valid <= 1'b0;
`ifdef SCCB_SLAVE_READ_EN
            rd_req   <= 1'b0;
`endif
            if (start_c) begin
                state       <= DEV;
                bit_cnt     <= 4'd0;
                ack_phase   <= 1'b0;
                i2c_sdat_oe <= 1'b0;
                busy        <= 1'b0;
`ifdef SCCB_SLAVE_READ_EN
                rd_stage    <= 2'd0;
`endif
            end else if (stop_c) begin
                state       <= IDLE;
                ack_phase   <= 1'b0;
                i2c_sdat_oe <= 1'b0;
                busy        <= 1'b0;
`ifdef SCCB_SLAVE_READ_EN
                rd_stage    <= 2'd0;
`endif
            end else if (ack_phase) begin
                // ACK slot ends on the falling edge after the 9th clock
                if (scl_fall) begin
                    ack_phase   <= 1'b0;
                    i2c_sdat_oe <= 1'b0;
                    bit_cnt     <= 4'd0;
                    state       <= ack_next;
`ifdef SCCB_SLAVE_READ_EN
                    if (ack_next == RD) begin
                        rd_req   <= 1'b1;
                        rd_addr  <= addr;
                        rd_stage <= 2'd1;
                    end
`endif
                end
            end else begin
                case (state)
                    DEV, AH, AL, WR: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shreg   <= {shreg[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (state == WR && bit_cnt == 4'd7) begin
                                wr_valid <= 1'b1;
                                wr_addr  <= addr;
                                wr_data  <= {shreg[6:0], sda_f};
                                addr     <= addr + 16'd1;
                                if (wr_count != 9'd511)
                                    wr_count <= wr_count + 9'd1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            ack_phase   <= 1'b1;
                            i2c_sdat_oe <= 1'b1;
                            case (state)
                                DEV: begin
                                    if (shreg == {DEV_ADDR, 1'b0}) begin
                                        ack_next <= AH;
                                        busy     <= 1'b1;
`ifdef SCCB_SLAVE_READ_EN
                                    end else if (addr_set && shreg == {DEV_ADDR, 1'b1}) begin
                                        ack_next <= RD;
                                        busy     <= 1'b1;
`endif
                                    end else begin
                                        ack_phase   <= 1'b0;
                                        i2c_sdat_oe <= 1'b0;
                                        state       <= WAIT_STOP;
                                    end
                                end
                                AH: begin
                                    addr[15:8] <= shreg;
                                    ack_next   <= AL;
                                end
                                AL: begin
                                    addr[7:0] <= shreg;
                                    ack_next  <= WR;
`ifdef SCCB_SLAVE_READ_EN
                                    addr_set  <= 1'b1;
`endif
                                end
                                default: ack_next <= WR;
                            endcase
                        end
                    end
`ifdef SCCB_SLAVE_READ_EN
                    RD: begin
                        // rd_data arrives one cycle after rd_req; first bit goes out once latched
                        if (rd_stage == 2'd1) begin
                            rd_stage <= 2'd2;
                        end else if (rd_stage == 2'd2) begin
                            shreg       <= rd_data;
                            i2c_sdat_oe <= ~rd_data[7];
                            bit_cnt     <= 4'd1;
                            rd_stage    <= 2'd0;
                        end else if (scl_fall) begin
                            if (bit_cnt < 4'd8) begin
                                i2c_sdat_oe <= ~shreg[6];
                                shreg       <= {shreg[6:0], 1'b0};
                                bit_cnt     <= bit_cnt + 4'd1;
                            end else begin
                                i2c_sdat_oe <= 1'b0;
                                state       <= MACK;
                            end
                        end
                    end
                    MACK: begin
                        if (scl_rise) begin
                            mack_ok <= ~sda_f;
                        end else if (scl_fall) begin
                            if (mack_ok) begin
                                addr     <= addr + 16'd1;
                                state    <= RD;
                                rd_req   <= 1'b1;
                                rd_addr  <= addr + 16'd1;
                                rd_stage <= 2'd1;
                            end else begin
                                state <= WAIT_STOP;
                                busy  <= 1'b0;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/sccb_reg_slave.md
Name: sccb_reg_slave

Overview:
- I2C/SCCB target (responder) for the 3-phase register writes our camera config master issues: device address, 16-bit register address, 8-bit data.
- Used as an on-board camera register model and in sim benches, to capture and check the full init sequence.
- Writes are emitted as single-cycle strobes.
- Reads are optional and served from an external register source.

Parameters:
- DEV_ADDR, 7'h3C, 7-bit target address (0x78 write / 0x79 read on the wire).
- FILTER_LEN, 3, consecutive equal samples needed before a filtered SCL/SDA level changes.

Ports:
- clk_25M  in  1  system clock.
- camera_rst  in  1  synchronous, active-high reset.
- i2c_sclk  in  1  bus SCL (asynchronous).
- i2c_sdat_in  in  1  bus SDA level (asynchronous).
- i2c_sdat_oe  out  1  1 = pull SDA low (open-drain driver outside this block).
- wr_valid  out  1  one-cycle write strobe.
- wr_addr  out  16  register address for the write.
- wr_data  out  8  register data for the write.
- rd_req  out  1  one-cycle read request.
- rd_addr  out  16  register address for the read.
- rd_data  in  8  read data, valid the cycle after rd_req.
- busy  out  1  high between an addressed START and the STOP/abort.
- wr_count  out  9  total accepted writes, saturates at 511.

Behaviour:
- Input conditioning:
  - 2-flop synchronizer, then a FILTER_LEN glitch filter, on both SCL and SDA.
  - All edge detection uses the filtered signals, one-cycle edge flags.
- Bus conditions:
  - START / repeated START: filtered SDA falls while SCL high.
  - STOP: filtered SDA rises while SCL high.
- Bit timing:
  - Data bits sampled on SCL rising edge, MSB first.
  - Target drives SDA only right after an SCL falling edge.
- States:
  - IDLE.
  - DEV: 8 bits. Match {DEV_ADDR,0} -> ACK -> AH. Match {DEV_ADDR,1} -> ACK -> RD, only if a register address is already set. Otherwise -> NOACK -> WAIT_STOP.
  - AH: 8 bits -> ACK -> AL.
  - AL: 8 bits -> ACK -> WR.
  - WR: 8 bits -> wr_valid, then ACK -> WR.
  - RD: drive 8 bits -> MACK. Master ACK -> RD. Master NACK -> WAIT_STOP.
  - WAIT_STOP: SDA released; ignores bits until START or STOP.
- ACK drive: i2c_sdat_oe=1 from the SCL falling edge after the 8th bit to the next SCL falling edge, then 0.
- Write strobe:
  - wr_valid pulses exactly 1 cycle, the cycle after the 8th data bit's rising-edge flag.
  - wr_addr/wr_data hold until the next strobe.
  - Address auto-increments after each data byte, wrapping 0xFFFF -> 0x0000.
  - wr_count increments on each wr_valid, saturating at 511.
- Read path:
  - rd_req pulses on entering RD with rd_addr = current address.
  - rd_data is latched the following cycle.
  - Bit n is driven from the SCL falling edge (oe = ~bit).
  - Address increments after each byte acked by the master.
- START in any state: abort the current byte, release SDA, go to DEV. A partially received data byte produces no write.
- STOP in any state: release SDA -> IDLE, busy=0.
- busy=1 from the DEV match to STOP/START-abort or WAIT_STOP.
- Reset (also mid-transfer), next cycle:
  - All outputs 0, i2c_sdat_oe=0, state IDLE.
  - wr_addr, rd_addr, wr_count cleared.
  - No pending strobe survives.
- START/STOP takes priority over a simultaneous SCL edge.

Optional Feature:
- Macro: SCCB_SLAVE_READ_EN.
- Defined: RD/MACK states and the rd_req/rd_addr/rd_data path are present.
- Undefined: {DEV_ADDR,1} is NACKed -> WAIT_STOP. rd_req and rd_addr are tied to 0; rd_data is unused.

Test Plan:
- Single write: START, 0x78, 0x31, 0x03, 0x11, STOP at 10 kHz SCL -> ACK on all 4 bytes, one wr_valid with wr_addr=0x3103, wr_data=0x11, wr_count=1, busy 0 after STOP.
- Wrong address: START, 0x7A, ... -> no ACK (oe stays 0), no wr_valid, busy stays 0.
- Burst: 0x78, 0x58, 0x00, 0x23, 0x14, 0x0F -> three strobes at 0x5800/0x5801/0x5802 with data 0x23/0x14/0x0F.
- Read (macro defined): write 0x78, 0x30, 0x0A; Sr; 0x79; rd_data=0x56; master NACK; STOP -> rd_req with rd_addr=0x300A, SDA bits 01010110, SDA released after the byte, IDLE after STOP. Undefined: 0x79 NACKed.
- Robustness: 1-cycle SDA glitch while SCL high -> no START/STOP. Assert camera_rst during the AL byte -> oe=0 next cycle, wr_count=0, next transaction decodes normally.
- Full init: 357 write transactions -> wr_count=357 and the last strobe is addr=0x3503, data=0x00.
